// File: rtl/apb_demux_wdt.sv
// APB4 one-to-many demux with address decoder, decode-error responder
// and a per-transfer watchdog that aborts stalled slaves.
module apb_demux_wdt #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned NoSlv         = 4,
  parameter int unsigned StrbWidth     = (DataWidth + 7) / 8,
  parameter logic [NoSlv-1:0][AddrWidth-1:0] RuleBase = '0,
  parameter logic [NoSlv-1:0][AddrWidth-1:0] RuleMask = '0,
  parameter int unsigned TimeoutCycles = 16,
  parameter int unsigned SelWidth      = (NoSlv > 1) ? $clog2(NoSlv) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [AddrWidth-1:0]       mst_paddr_i,
  input  logic                       mst_psel_i,
  input  logic                       mst_penable_i,
  input  logic                       mst_pwrite_i,
  input  logic [DataWidth-1:0]       mst_pwdata_i,
  input  logic [StrbWidth-1:0]       mst_pstrb_i,
  output logic                       mst_pready_o,
  output logic [DataWidth-1:0]       mst_prdata_o,
  output logic                       mst_pslverr_o,
  output logic [AddrWidth-1:0]       slv_paddr_o,
  output logic                       slv_pwrite_o,
  output logic [DataWidth-1:0]       slv_pwdata_o,
  output logic [StrbWidth-1:0]       slv_pstrb_o,
  output logic                       slv_penable_o,
  output logic [NoSlv-1:0]           slv_psel_o,
  input  logic [NoSlv-1:0]           slv_pready_i,
  input  logic [NoSlv*DataWidth-1:0] slv_prdata_i,
  input  logic [NoSlv-1:0]           slv_pslverr_i,
  output logic                       timeout_o,
  output logic [SelWidth-1:0]        timeout_idx_o
);

  localparam int unsigned CntW =
    (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ERR
  } state_e;

  state_e               state_q, state_d;
  logic [SelWidth-1:0]  sel_q, sel_d, idx;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 dec_err, to_d;
  logic [NoSlv-1:0]     dec_oh, sel_oh;
  logic [DataWidth-1:0] rdata;
  logic                 rready, rerr;

  assign slv_paddr_o   = mst_paddr_i;
  assign slv_pwrite_o  = mst_pwrite_i;
  assign slv_pwdata_o  = mst_pwdata_i;
  assign slv_pstrb_o   = mst_pstrb_i;
  assign slv_penable_o = mst_penable_i;

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    idx     = '0;
    dec_err = 1'b1;
    dec_oh  = '0;
    for (int i = int'(NoSlv) - 1; i >= 0; i--) begin
      if ((mst_paddr_i & RuleMask[i]) == RuleBase[i]) begin
        idx     = SelWidth'(i);
        dec_err = 1'b0;
        dec_oh  = '0;
        dec_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rdata  = '0;
    rready = 1'b0;
    rerr   = 1'b0;
    sel_oh = '0;
    for (int i = 0; i < int'(NoSlv); i++) begin
      if (sel_q == SelWidth'(i)) begin
        rdata     = slv_prdata_i[i*DataWidth +: DataWidth];
        rready    = slv_pready_i[i];
        rerr      = slv_pslverr_i[i];
        sel_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    to_d          = 1'b0;
    slv_psel_o    = '0;
    mst_pready_o  = 1'b0;
    mst_prdata_o  = '0;
    mst_pslverr_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mst_psel_i && !mst_penable_i) begin
          sel_d      = idx;
          slv_psel_o = dec_err ? '0 : dec_oh;
          state_d    = dec_err ? ERR : ACCESS;
        end
      end
      ACCESS: begin
        if (!mst_psel_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          slv_psel_o = sel_oh;
          if (mst_penable_i) begin
            if (rready) begin
              mst_pready_o  = 1'b1;
              mst_prdata_o  = rdata;
              mst_pslverr_o = rerr;
              state_d       = IDLE;
              cnt_d         = '0;
            end else if (TimeoutCycles != 0 && cnt_q == CntMax) begin
              // Ending the master transfer drops psel: that is the abort.
              mst_pready_o  = 1'b1;
              mst_pslverr_o = 1'b1;
              to_d          = 1'b1;
              state_d       = IDLE;
              cnt_d         = '0;
            end else if (cnt_q != '1) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      ERR: begin
        if (!mst_psel_i) begin
          state_d = IDLE;
        end else if (mst_penable_i) begin
          mst_pready_o  = 1'b1;
          mst_pslverr_o = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      cnt_q         <= '0;
      timeout_o     <= 1'b0;
      timeout_idx_o <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      timeout_o <= to_d;
      if (to_d) timeout_idx_o <= sel_q;
    end
  end

endmodule

// File: tb/tb_apb_demux_wdt.sv
// Bench for apb_demux_wdt: directed plan steps then random transfers,
// checked against a transaction-level outcome model.
module tb_apb_demux_wdt;

  localparam int NS = 4;
  localparam int TO = 16;
  localparam logic [NS-1:0][31:0] BASE =
    {32'h0000_4000, 32'h0000_1000, 32'h0000_2000, 32'h0000_1000};
  localparam logic [NS-1:0][31:0] MASK =
    {32'hFFFF_F000, 32'hFFFF_D000, 32'hFFFF_F000, 32'hFFFF_F000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        m_ready, m_err;
  logic [31:0] m_rdata;
  logic [31:0] s_addr, s_wdata;
  logic        s_write, s_enable;
  logic [3:0]  s_strb, s_sel;
  logic [NS-1:0]    s_ready = '0;
  logic [NS*32-1:0] s_rdata = '0;
  logic [NS-1:0]    s_err = '0;
  logic        to_pulse;
  logic [1:0]  to_idx;

  int   tests = 0;
  int   fails = 0;
  bit   pend_to = 1'b0;
  int   pend_idx = 0;
  bit   fix_en = 1'b0;
  logic [31:0] fix_rd = '0;

  always #5 clk = ~clk;

  apb_demux_wdt #(
    .AddrWidth(32), .DataWidth(32), .NoSlv(NS),
    .RuleBase(BASE), .RuleMask(MASK), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mst_paddr_i(paddr), .mst_psel_i(psel),
    .mst_penable_i(penable), .mst_pwrite_i(pwrite),
    .mst_pwdata_i(pwdata), .mst_pstrb_i(pstrb),
    .mst_pready_o(m_ready), .mst_prdata_o(m_rdata),
    .mst_pslverr_o(m_err),
    .slv_paddr_o(s_addr), .slv_pwrite_o(s_write),
    .slv_pwdata_o(s_wdata), .slv_pstrb_o(s_strb),
    .slv_penable_o(s_enable), .slv_psel_o(s_sel),
    .slv_pready_i(s_ready), .slv_prdata_i(s_rdata),
    .slv_pslverr_i(s_err),
    .timeout_o(to_pulse), .timeout_idx_o(to_idx)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First rule in index order that matches wins; -1 means unmapped.
  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & MASK[i]) == BASE[i]) return i;
    return -1;
  endfunction

  task automatic drive_slaves(input int tgt, input bit rdy,
                              input bit serr, output logic [31:0] rd);
    for (int i = 0; i < NS; i++) begin
      s_ready[i] = 1'($urandom);
      s_err[i]   = 1'($urandom);
      s_rdata[i*32 +: 32] = $urandom;
    end
    rd = '0;
    if (tgt >= 0) begin
      s_ready[tgt] = rdy;
      s_err[tgt]   = serr;
      if (fix_en) s_rdata[tgt*32 +: 32] = fix_rd;
      rd = s_rdata[tgt*32 +: 32];
    end
  endtask

  task automatic check_pulse(input string tag);
    chk({tag, "_to"}, 64'(to_pulse), 64'(pend_to));
    if (pend_to) chk({tag, "_to_idx"}, 64'(to_idx), 64'(pend_idx));
    pend_to = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    psel = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    check_pulse("idle");
    chk("idle_resp", {m_ready, m_err, m_rdata}, '0);
    chk("idle_psel", 64'(s_sel), '0);
  endtask

  // abort_kind: 0 none, 1 reset during wait cycle abort_at,
  // 2 master drops psel after wait cycle abort_at.
  task automatic xfer(input logic [31:0] addr, input bit wr,
                      input logic [31:0] wd, input logic [3:0] st,
                      input int stall, input bit serr,
                      input int abort_at, input int abort_kind);
    int tgt;
    int w;
    bit rdy, er, ee;
    logic [3:0]  oh;
    logic [31:0] rd, ed;
    tgt = decode(addr);
    oh = '0;
    if (tgt >= 0) oh[tgt] = 1'b1;
    @(posedge clk); #1;
    psel = 1'b1;
    penable = 1'b0;
    paddr = addr;
    pwrite = wr;
    pwdata = wd;
    pstrb = st;
    drive_slaves(tgt, 1'b0, serr, rd);
    @(negedge clk);
    check_pulse("setup");
    chk("setup_psel", 64'(s_sel), 64'(oh));
    chk("setup_resp", {m_ready, m_err, m_rdata}, '0);
    chk("bcast", {s_addr, s_wdata}, {addr, wd});
    chk("bcast_ctl", {s_write, s_strb, s_enable}, {wr, st, 1'b0});
    @(posedge clk); #1;
    penable = 1'b1;
    for (w = 0; w < 40; w++) begin
      rdy = (tgt >= 0) && (w >= stall);
      drive_slaves(tgt, rdy, serr, rd);
      @(negedge clk);
      if (tgt < 0) begin
        er = 1; ee = 1; ed = '0;
      end else if (rdy) begin
        er = 1; ee = serr; ed = rd;
      end else if (w == TO) begin
        er = 1; ee = 1; ed = '0;
        pend_to = 1'b1;
        pend_idx = tgt;
      end else begin
        er = 0; ee = 0; ed = '0;
      end
      chk("acc_psel", 64'(s_sel), 64'(oh));
      chk("acc_resp", {m_ready, m_err, m_rdata}, {er, ee, ed});
      chk("acc_no_to", 64'(to_pulse), '0);
      if (!er && w == abort_at && abort_kind == 1) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_now", {s_sel, m_ready, to_pulse}, '0);
        psel = 1'b0;
        penable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hold", {s_sel, m_ready, to_pulse, to_idx}, '0);
        rst_n = 1'b1;
        return;
      end
      if (!er && w == abort_at && abort_kind == 2) begin
        @(posedge clk); #1;
        psel = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        chk("drop_resp", {s_sel, m_ready, m_err}, '0);
        return;
      end
      if (er) break;
      @(posedge clk); #1;
    end
    if (w >= 40) begin
      tests++;
      fails++;
      $error("FAIL xfer_bound observed=no_ready expected=ready");
    end
  endtask

  initial begin
    @(negedge clk);
    chk("rst_state", {m_ready, m_err, m_rdata, s_sel, to_pulse, to_idx}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    fix_en = 1'b1;
    fix_rd = 32'hCAFE_0001;
    xfer(32'h2004, 1'b0, '0, 4'h0, 0, 1'b0, -1, 0);
    fix_en = 1'b0;
    xfer(32'h3010, 1'b1, 32'hA5A5_A5A5, 4'hF, 3, 1'b0, -1, 0);
    xfer(32'h9000, 1'b0, '0, 4'h0, 0, 1'b0, -1, 0);
    xfer(32'h4000, 1'b0, '0, 4'h0, 100, 1'b0, -1, 0);
    xfer(32'h0000_1000, 1'b0, '0, 4'h0, 1, 1'b0, -1, 0);
    xfer(32'h0000_1008, 1'b1, 32'h1234_5678, 4'h3, 0, 1'b1, -1, 0);
    xfer(32'h3000, 1'b0, '0, 4'h0, 100, 1'b0, 3, 2);
    idle();
    xfer(32'h4010, 1'b0, '0, 4'h0, 100, 1'b0, 4, 1);
    xfer(32'h2000, 1'b0, '0, 4'h0, 2, 1'b0, -1, 0);
    idle();

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = {16'h0, 4'($urandom_range(0, 9)), 12'($urandom)};
      if ($urandom_range(0, 9) == 0) a[31:16] = 16'($urandom);
      xfer(a, 1'($urandom), $urandom, 4'($urandom),
           int'($urandom_range(0, 20)), 1'($urandom), -1, 0);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
